// File: rtl/mac_fwd_ctrl_pkg.sv
`default_nettype none
// mac_fwd_ctrl_pkg: FSM states, header byte layout and decision type. Rev 1.0
package mac_fwd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DECIDE = 3'd4
  } state_t;

  // DA occupies header bytes 0-5, SA bytes 6-11
  localparam logic [3:0] DA_FIRST_BYTE = 4'd0;
  localparam logic [3:0] DA_LAST_BYTE  = 4'd5;
  localparam logic [3:0] SA_LAST_BYTE  = 4'd11;

  // I/G bit: LSB of the first address byte on the wire
  localparam int GROUP_BIT = 40;

  localparam int DEC_PORT_W = 1;

  typedef struct packed {
    logic                  flood;
    logic                  drop;
    logic [DEC_PORT_W-1:0] port;
  } decision_t;

endpackage
`default_nettype wire

// File: rtl/mac_fwd_ctrl_hdr_capture.sv
`default_nettype none
// mac_hdr_capture: header byte counter with DA/SA shift registers. Rev 1.0
module mac_hdr_capture
  import mac_fwd_ctrl_pkg::*;
(
  input  logic        iclk,
  input  logic        i_rst_n,
  input  logic        active,
  input  logic        valid,
  input  logic [7:0]  data,
  input  logic        sof,
  input  logic        eof,
  output logic [47:0] da,
  output logic [47:0] sa,
  output logic        hdr_done,
  output logic        runt
);

  logic [3:0]  byte_cnt;
  logic [39:0] sa_head;
  logic        shift_en;

  assign shift_en = active & valid & ~sof;
  assign hdr_done = shift_en & (byte_cnt == SA_LAST_BYTE);
  assign runt     = valid & eof & (sof | (active & (byte_cnt != SA_LAST_BYTE)));

  // Byte 11 is never stored: the full SA is formed with the live byte
  assign sa = {sa_head, data};

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt <= '0;
      da       <= '0;
      sa_head  <= '0;
    end else if (valid & sof) begin
      byte_cnt <= DA_FIRST_BYTE + 4'd1;
      da       <= {da[39:0], data};
    end else if (shift_en && (byte_cnt != SA_LAST_BYTE)) begin
      byte_cnt <= byte_cnt + 4'd1;
      if (byte_cnt <= DA_LAST_BYTE) begin
        da <= {da[39:0], data};
      end else begin
        sa_head <= {sa_head[31:0], data};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_fwd_ctrl.sv
`default_nettype none
// mac_fwd_ctrl: parses frame headers, drives MAC table learn/lookup and
// issues a unicast/flood/filter decision over valid/ready. Rev 1.0
module mac_fwd_ctrl
  import mac_fwd_ctrl_pkg::*;
#(
  parameter int pMAC_W      = 48,
  parameter int pPORT_W     = DEC_PORT_W,
  parameter int pLOOKUP_LAT = 1,
  parameter int pCNT_W      = 16
) (
  input  logic               iclk,
  input  logic               i_rst_n,
  input  logic [pPORT_W-1:0] i_port_id,
  input  logic               i_valid,
  input  logic [7:0]         i_data,
  input  logic               i_sof,
  input  logic               i_eof,
  output logic               o_write_enable,
  output logic [pPORT_W-1:0] o_port_num,
  output logic [pMAC_W-1:0]  o_mac_sa,
  output logic [pMAC_W-1:0]  o_mac_da,
  input  logic [pPORT_W-1:0] i_lookup_port,
  output logic               o_dec_valid,
  input  logic               i_dec_ready,
  output logic               o_dec_flood,
  output logic               o_dec_drop,
  output logic [pPORT_W-1:0] o_dec_port,
  output logic [pCNT_W-1:0]  o_drop_cnt
);

  localparam int              WAIT_W    = (pLOOKUP_LAT > 1) ? $clog2(pLOOKUP_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(pLOOKUP_LAT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [47:0]       cap_da, cap_sa;
  logic              hdr_active, hdr_done, runt;
  logic              start, slot_free;
  logic              req_go, drop_go, dec_go;
  decision_t         dec_q, dec_nxt;

  assign hdr_active = (state == ST_HDR);
  assign start      = i_valid & i_sof;
  assign slot_free  = ~o_dec_valid | i_dec_ready;

  mac_hdr_capture u_hdr (
    .iclk     (iclk),
    .i_rst_n  (i_rst_n),
    .active   (hdr_active),
    .valid    (i_valid),
    .data     (i_data),
    .sof      (i_sof),
    .eof      (i_eof),
    .da       (cap_da),
    .sa       (cap_sa),
    .hdr_done (hdr_done),
    .runt     (runt)
  );

  always_comb begin
    state_nxt      = state;
    req_go         = 1'b0;
    dec_go         = 1'b0;
    o_write_enable = 1'b0;
    drop_go        = runt | (hdr_done & ~slot_free);
    dec_nxt.flood  = o_mac_da[GROUP_BIT];
    dec_nxt.drop   = ~o_mac_da[GROUP_BIT] & (i_lookup_port == i_port_id);
    dec_nxt.port   = DEC_PORT_W'(i_lookup_port);
    unique case (state)
      ST_IDLE: ;
      ST_HDR: begin
        if (runt) begin
          state_nxt = ST_IDLE;
        end else if (hdr_done) begin
          req_go    = slot_free;
          state_nxt = slot_free ? ST_REQ : ST_IDLE;
        end
      end
      ST_REQ: begin
        o_write_enable = ~o_mac_sa[GROUP_BIT];
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          dec_go    = 1'b1;
          state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // A new frame start overrides everything; a pending lookup is abandoned
    if (start) begin
      state_nxt = i_eof ? ST_IDLE : ST_HDR;
      dec_go    = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      o_mac_da    <= '0;
      o_mac_sa    <= '0;
      o_dec_valid <= 1'b0;
      dec_q       <= '0;
      o_drop_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (req_go) begin
        o_mac_da <= pMAC_W'(cap_da);
        o_mac_sa <= pMAC_W'(cap_sa);
      end
      if (dec_go) begin
        o_dec_valid <= 1'b1;
        dec_q       <= dec_nxt;
      end else if (i_dec_ready) begin
        o_dec_valid <= 1'b0;
      end
      if (drop_go && (o_drop_cnt != '1)) begin
        o_drop_cnt <= o_drop_cnt + 1'b1;
      end
    end
  end

  assign o_port_num  = i_port_id;
  assign o_dec_flood = dec_q.flood;
  assign o_dec_drop  = dec_q.drop;
  assign o_dec_port  = pPORT_W'(dec_q.port);

endmodule
`default_nettype wire

// File: tb/tb_mac_fwd_ctrl.sv
`default_nettype none
// tb_mac_fwd_ctrl: scenario tasks plus randomized frames against a frame-level model.
module tb_mac_fwd_ctrl;

  localparam int PORT_W = 1;

  logic              iclk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [PORT_W-1:0] i_port_id = '0;
  logic              i_valid = 1'b0;
  logic [7:0]        i_data = '0;
  logic              i_sof = 1'b0;
  logic              i_eof = 1'b0;
  logic              o_write_enable;
  logic [PORT_W-1:0] o_port_num;
  logic [47:0]       o_mac_sa, o_mac_da;
  logic [PORT_W-1:0] i_lookup_port = '0;
  logic              o_dec_valid;
  logic              i_dec_ready = 1'b1;
  logic              o_dec_flood, o_dec_drop;
  logic [PORT_W-1:0] o_dec_port;
  logic [15:0]       o_drop_cnt;

  mac_fwd_ctrl dut (
    .iclk(iclk), .i_rst_n(i_rst_n), .i_port_id(i_port_id),
    .i_valid(i_valid), .i_data(i_data), .i_sof(i_sof), .i_eof(i_eof),
    .o_write_enable(o_write_enable), .o_port_num(o_port_num),
    .o_mac_sa(o_mac_sa), .o_mac_da(o_mac_da), .i_lookup_port(i_lookup_port),
    .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready),
    .o_dec_flood(o_dec_flood), .o_dec_drop(o_dec_drop),
    .o_dec_port(o_dec_port), .o_drop_cnt(o_drop_cnt)
  );

  always #5 iclk = ~iclk;

  int unsigned cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int unsigned hdr_cyc = 0;
  bit rand_ready = 1'b0;

  // Observed learn pulses and decision transfers
  logic [47:0]       we_sa_q[$];
  logic [47:0]       we_da_q[$];
  logic [PORT_W-1:0] we_port_q[$];
  int unsigned       we_cyc_q[$];
  logic [PORT_W+1:0] dec_q[$];
  int unsigned       rise_q[$];
  logic              prev_valid = 1'b0;

  always @(negedge iclk) begin
    if (o_write_enable) begin
      we_sa_q.push_back(o_mac_sa);
      we_da_q.push_back(o_mac_da);
      we_port_q.push_back(o_port_num);
      we_cyc_q.push_back(cyc);
    end
    if (o_dec_valid && i_dec_ready) dec_q.push_back({o_dec_flood, o_dec_drop, o_dec_port});
    if (o_dec_valid && !prev_valid) rise_q.push_back(cyc);
    prev_valid <= o_dec_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1);
  end

  task automatic clear_mon();
    we_sa_q.delete(); we_da_q.delete(); we_port_q.delete(); we_cyc_q.delete();
    dec_q.delete(); rise_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rand_ready) i_dec_ready = 1'($urandom_range(0, 1));
      @(posedge iclk); #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
    i_valid = 1'b1; i_data = d; i_sof = s; i_eof = e;
    if (rand_ready) i_dec_ready = 1'($urandom_range(0, 1));
    @(posedge iclk); #1;
    i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] da, input logic [47:0] sa,
                            input int len, input bit with_eof);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (i < 6)       b = da[47-8*i -: 8];
      else if (i < 12) b = sa[47-8*(i-6) -: 8];
      else             b = 8'($urandom);
      if (i == 11) hdr_cyc = cyc;
      drive_byte(b, i == 0, with_eof && (i == len - 1));
    end
  endtask

  task automatic test_reset();
    #12;
    tests++; if (o_write_enable !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", o_write_enable); end
    tests++; if (o_dec_valid !== 1'b0) begin fails++; $display("FAIL rst_dec_valid: got %b want 0", o_dec_valid); end
    tests++; if ({o_dec_flood, o_dec_drop} !== 2'b00) begin fails++; $display("FAIL rst_flood_drop: got %b want 00", {o_dec_flood, o_dec_drop}); end
    tests++; if (o_dec_port !== '0) begin fails++; $display("FAIL rst_dec_port: got %0h want 0", o_dec_port); end
    tests++; if (o_mac_da !== 48'h0) begin fails++; $display("FAIL rst_mac_da: got %h want 0", o_mac_da); end
    tests++; if (o_mac_sa !== 48'h0) begin fails++; $display("FAIL rst_mac_sa: got %h want 0", o_mac_sa); end
    tests++; if (o_drop_cnt !== 16'h0) begin fails++; $display("FAIL rst_drop_cnt: got %0d want 0", o_drop_cnt); end
    i_port_id = 1'b1; #1;
    tests++; if (o_port_num !== 1'b1) begin fails++; $display("FAIL rst_port_num: got %0h want 1", o_port_num); end
    i_port_id = 1'b0;
    @(posedge iclk); #1; i_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_unicast();
    logic [47:0] da = 48'h02_00_00_00_00_01;
    logic [47:0] sa = 48'h02_00_00_00_00_02;
    i_port_id = 1'b0; i_lookup_port = 1'b1; clear_mon();
    send_frame(da, sa, 16, 1'b1); idle(8);
    tests++; if (we_sa_q.size() !== 1) begin fails++; $display("FAIL uni_we_count: got %0d want 1", we_sa_q.size()); end
    if (we_sa_q.size() > 0) begin
      tests++; if (we_sa_q[0] !== sa) begin fails++; $display("FAIL uni_mac_sa: got %h want %h", we_sa_q[0], sa); end
      tests++; if (we_da_q[0] !== da) begin fails++; $display("FAIL uni_mac_da: got %h want %h", we_da_q[0], da); end
      tests++; if (we_port_q[0] !== 1'b0) begin fails++; $display("FAIL uni_port_num: got %0h want 0", we_port_q[0]); end
      tests++; if (we_cyc_q[0] !== hdr_cyc + 1) begin fails++; $display("FAIL uni_we_cycle: got %0d want %0d", we_cyc_q[0], hdr_cyc + 1); end
    end
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL uni_dec_count: got %0d want 1", dec_q.size()); end
    if (dec_q.size() > 0) begin
      tests++; if (dec_q[0] !== 3'b001) begin fails++; $display("FAIL uni_dec: got %b want 001", dec_q[0]); end
    end
    if (rise_q.size() > 0) begin
      tests++; if (rise_q[0] !== hdr_cyc + 3) begin fails++; $display("FAIL uni_dec_latency: got %0d want %0d", rise_q[0], hdr_cyc + 3); end
    end
  endtask

  task automatic test_broadcast();
    i_port_id = 1'b0; i_lookup_port = 1'b1; clear_mon();
    send_frame(48'hFF_FF_FF_FF_FF_FF, 48'h02_AA_BB_CC_DD_EE, 14, 1'b1); idle(8);
    tests++; if (we_sa_q.size() !== 1) begin fails++; $display("FAIL bc_we_count: got %0d want 1", we_sa_q.size()); end
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL bc_dec_count: got %0d want 1", dec_q.size()); end
    if (dec_q.size() > 0) begin
      tests++; if (dec_q[0][2:1] !== 2'b10) begin fails++; $display("FAIL bc_flood_drop: got %b want 10", dec_q[0][2:1]); end
    end
  endtask

  task automatic test_filter();
    i_port_id = 1'b1; i_lookup_port = 1'b1; clear_mon();
    send_frame(48'h02_00_00_00_00_07, 48'h02_00_00_00_00_08, 12, 1'b1); idle(8);
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL filt_dec_count: got %0d want 1", dec_q.size()); end
    if (dec_q.size() > 0) begin
      tests++; if (dec_q[0][2:1] !== 2'b01) begin fails++; $display("FAIL filt_flood_drop: got %b want 01", dec_q[0][2:1]); end
    end
  endtask

  task automatic test_group_sa();
    i_port_id = 1'b0; i_lookup_port = 1'b1; clear_mon();
    send_frame(48'h02_00_00_00_00_03, 48'h01_00_5E_00_00_01, 15, 1'b1); idle(8);
    tests++; if (we_sa_q.size() !== 0) begin fails++; $display("FAIL gsa_we_count: got %0d want 0", we_sa_q.size()); end
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL gsa_dec_count: got %0d want 1", dec_q.size()); end
  endtask

  task automatic test_runt();
    logic [15:0] d0 = o_drop_cnt;
    logic [47:0] sa_b = 48'h06_11_22_33_44_55;
    i_port_id = 1'b0; i_lookup_port = 1'b1; clear_mon();
    send_frame(48'h02_00_00_00_00_09, 48'h02_00_00_00_00_0A, 8, 1'b1); idle(8);
    tests++; if (we_sa_q.size() !== 0) begin fails++; $display("FAIL runt_we_count: got %0d want 0", we_sa_q.size()); end
    tests++; if (dec_q.size() !== 0) begin fails++; $display("FAIL runt_dec_count: got %0d want 0", dec_q.size()); end
    tests++; if (o_drop_cnt !== d0 + 16'd1) begin fails++; $display("FAIL runt_drop_cnt: got %0d want %0d", o_drop_cnt, d0 + 16'd1); end
    clear_mon();
    send_frame(48'h02_00_00_00_00_0B, 48'h02_00_00_00_00_0C, 5, 1'b0);
    send_frame(48'h04_00_00_00_00_0D, sa_b, 13, 1'b1); idle(8);
    tests++; if (we_sa_q.size() !== 1) begin fails++; $display("FAIL restart_we_count: got %0d want 1", we_sa_q.size()); end
    if (we_sa_q.size() > 0) begin
      tests++; if (we_sa_q[0] !== sa_b) begin fails++; $display("FAIL restart_mac_sa: got %h want %h", we_sa_q[0], sa_b); end
    end
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL restart_dec_count: got %0d want 1", dec_q.size()); end
    if (dec_q.size() > 0) begin
      tests++; if (dec_q[0] !== 3'b001) begin fails++; $display("FAIL restart_dec: got %b want 001", dec_q[0]); end
    end
    tests++; if (o_drop_cnt !== d0 + 16'd1) begin fails++; $display("FAIL restart_drop_cnt: got %0d want %0d", o_drop_cnt, d0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d0 = o_drop_cnt;
    i_port_id = 1'b0; i_lookup_port = 1'b1; i_dec_ready = 1'b0; clear_mon();
    send_frame(48'h02_00_00_00_00_21, 48'h02_00_00_00_00_22, 12, 1'b1); idle(6);
    tests++; if (o_dec_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid: got %b want 1", o_dec_valid); end
    i_lookup_port = 1'b0;
    send_frame(48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_00_23, 14, 1'b1); idle(6);
    tests++; if ({o_dec_valid, o_dec_flood, o_dec_drop, o_dec_port} !== 4'b1001) begin
      fails++; $display("FAIL bp_hold: got %b want 1001", {o_dec_valid, o_dec_flood, o_dec_drop, o_dec_port}); end
    tests++; if (o_drop_cnt !== d0 + 16'd1) begin fails++; $display("FAIL bp_drop_cnt: got %0d want %0d", o_drop_cnt, d0 + 16'd1); end
    tests++; if (we_sa_q.size() !== 1) begin fails++; $display("FAIL bp_we_count: got %0d want 1", we_sa_q.size()); end
    i_dec_ready = 1'b1; @(posedge iclk); #1; i_dec_ready = 1'b0; idle(3);
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL bp_transfers: got %0d want 1", dec_q.size()); end
    if (dec_q.size() > 0) begin
      tests++; if (dec_q[0] !== 3'b001) begin fails++; $display("FAIL bp_dec: got %b want 001", dec_q[0]); end
    end
    tests++; if (o_dec_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_clear: got %b want 0", o_dec_valid); end
    i_dec_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [47:0] da, sa;
    int len;
    logic [15:0] d0;
    bit exp_we, exp_flood, exp_drop;
    rand_ready = 1'b1;
    i_port_id = 1'($urandom);
    for (int f = 0; f < 40; f++) begin
      clear_mon();
      da = {16'($urandom), $urandom};
      sa = {16'($urandom), $urandom};
      len = $urandom_range(6, 18);
      i_lookup_port = 1'($urandom);
      d0 = o_drop_cnt;
      send_frame(da, sa, len, 1'b1);
      idle(4);
      for (int k = 0; k < 64 && o_dec_valid; k++) idle(1);
      tests++; if (o_dec_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_drain: decision still pending", f); end
      if (len < 12) begin
        tests++; if ({we_sa_q.size(), dec_q.size()} !== 64'd0) begin
          fails++; $display("FAIL rnd%0d_runt: we=%0d dec=%0d want 0/0", f, we_sa_q.size(), dec_q.size()); end
        tests++; if (o_drop_cnt !== d0 + 16'd1) begin fails++; $display("FAIL rnd%0d_drop: got %0d want %0d", f, o_drop_cnt, d0 + 16'd1); end
      end else begin
        exp_we = !sa[40];
        exp_flood = da[40];
        exp_drop = !exp_flood && (i_lookup_port == i_port_id);
        tests++; if (we_sa_q.size() !== int'(exp_we)) begin fails++; $display("FAIL rnd%0d_we: got %0d want %0d", f, we_sa_q.size(), exp_we); end
        tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL rnd%0d_dec_count: got %0d want 1", f, dec_q.size()); end
        if (dec_q.size() > 0) begin
          tests++; if (dec_q[0][2:1] !== {exp_flood, exp_drop}) begin
            fails++; $display("FAIL rnd%0d_dec: got %b want %b", f, dec_q[0][2:1], {exp_flood, exp_drop}); end
          if (!exp_flood && !exp_drop) begin
            tests++; if (dec_q[0][0] !== i_lookup_port) begin fails++; $display("FAIL rnd%0d_port: got %0h want %0h", f, dec_q[0][0], i_lookup_port); end
          end
        end
      end
    end
    rand_ready = 1'b0; i_dec_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    i_port_id = 1'b0; i_lookup_port = 1'b1;
    send_frame(48'h02_00_00_00_00_31, 48'h02_00_00_00_00_32, 7, 1'b0);
    #3 i_rst_n = 1'b0; #1;
    tests++; if (o_drop_cnt !== 16'h0) begin fails++; $display("FAIL arst_drop_cnt: got %0d want 0", o_drop_cnt); end
    tests++; if (o_mac_sa !== 48'h0) begin fails++; $display("FAIL arst_mac_sa: got %h want 0", o_mac_sa); end
    @(posedge iclk); #1; i_rst_n = 1'b1; clear_mon();
    send_frame(48'h02_00_00_00_00_33, 48'h02_00_00_00_00_34, 12, 1'b1); idle(8);
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL arst_after_dec: got %0d want 1", dec_q.size()); end
    tests++; if (o_drop_cnt !== 16'h0) begin fails++; $display("FAIL arst_after_drop: got %0d want 0", o_drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_filter();
    test_group_sa();
    test_runt();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
